// File: rtl/bram_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : bram_port_arbiter                                       |
// | Purpose  : Round-robin arbiter sharing one BRAM port among NREQ    |
// |            requesters; single-word reads/writes via req/gnt and    |
// |            read data returned tagged to the issuing requester.     |
// | Option   : define BRAM_ARB_LOCK_EN to add a per-requester lock     |
// |            input that lets a granted requester own the port.       |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module bram_port_arbiter #(
  parameter int NREQ   = 4,
  parameter int AW     = 10,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    we,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
`ifdef BRAM_ARB_LOCK_EN
  input  logic [NREQ-1:0]    lock,
`endif
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rvalid,
  output logic [DW-1:0]      rdata,
  output logic               bram_wren,
  output logic               bram_rden,
  output logic [AW-1:0]      bram_addr,
  output logic [DW-1:0]      bram_din,
  input  logic [DW-1:0]      bram_dout
);

  localparam int              c_pw      = (NREQ > 1) ? $clog2(NREQ) : 1;
  // Pointer resets to the last index so requester 0 is searched first.
  localparam logic [c_pw-1:0] c_ptr_rst = c_pw'(NREQ - 1);

  logic [NREQ-1:0] r_gnt;
  logic            r_wren;
  logic            r_rden;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_din;
  logic [c_pw-1:0] r_rr_ptr;
  logic [NREQ-1:0] r_rvalid;
  logic [DW-1:0]   r_rdata;
  // Read-owner tags: stage 0 aligns with bram_rden, stage RD_LAT with valid dout.
  logic [NREQ-1:0] r_tag [0:RD_LAT];

  logic [NREQ-1:0] w_elig;
  logic            w_found;
  logic [c_pw-1:0] w_winner;
  logic [NREQ-1:0] w_win_oh;
  logic            w_sel_we;
  logic [AW-1:0]   w_sel_addr;
  logic [DW-1:0]   w_sel_din;

  // Wrap an index in [0, 2*NREQ) back into [0, NREQ); works for any NREQ.
  function automatic int f_wrap(input int v);
    return (v >= NREQ) ? (v - NREQ) : v;
  endfunction

`ifdef BRAM_ARB_LOCK_EN
  logic            r_own_vld;
  logic [c_pw-1:0] r_own;
  logic            w_own_hold;
  logic [NREQ-1:0] w_own_oh;

  // Eligible set: pending requests not granted last cycle, narrowed to the owner while its lock holds.
  always_comb begin
    w_own_oh          = '0;
    w_own_oh[r_own]   = 1'b1;
    w_own_hold        = r_own_vld & lock[r_own];
    w_elig            = req & ~r_gnt;
    if (w_own_hold) begin
      w_elig = w_elig & w_own_oh;
    end
  end

  // Ownership starts on a grant with lock set and ends the first cycle the owner's lock is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_own_vld <= 1'b0;
      r_own     <= '0;
    end else if (w_found && lock[w_winner]) begin
      r_own_vld <= 1'b1;
      r_own     <= w_winner;
    end else if (r_own_vld && !lock[r_own]) begin
      r_own_vld <= 1'b0;
    end
  end
`else
  // Eligible set: pending requests not granted last cycle (requester still sees gnt).
  always_comb w_elig = req & ~r_gnt;
`endif

  // Round-robin search starting just after the last winner.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_rr_ptr;
    for (int k = 1; k <= NREQ; k++) begin
      if (!w_found && w_elig[f_wrap(int'(r_rr_ptr) + k)]) begin
        w_found  = 1'b1;
        w_winner = c_pw'(f_wrap(int'(r_rr_ptr) + k));
      end
    end
  end

  // Select the winner's command fields.
  always_comb begin
    w_win_oh           = '0;
    w_win_oh[w_winner] = w_found;
    w_sel_we           = we[w_winner];
    w_sel_addr         = addr[int'(w_winner)*AW +: AW];
    w_sel_din          = wdata[int'(w_winner)*DW +: DW];
  end

  // Register the issue to the BRAM port; address/data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt    <= '0;
      r_wren   <= 1'b0;
      r_rden   <= 1'b0;
      r_addr   <= '0;
      r_din    <= '0;
      r_rr_ptr <= c_ptr_rst;
    end else begin
      r_gnt  <= w_win_oh;
      r_wren <= w_found & w_sel_we;
      r_rden <= w_found & ~w_sel_we;
      if (w_found) begin
        r_addr   <= w_sel_addr;
        r_din    <= w_sel_din;
        r_rr_ptr <= w_winner;
      end
    end
  end

  // Carry the read owner alongside the BRAM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s <= RD_LAT; s++) begin
        r_tag[s] <= '0;
      end
    end else begin
      r_tag[0] <= w_sel_we ? '0 : w_win_oh;
      for (int s = 1; s <= RD_LAT; s++) begin
        r_tag[s] <= r_tag[s-1];
      end
    end
  end

  // Capture returning read data with its owner tag; rdata holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid <= '0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= r_tag[RD_LAT];
      if (|r_tag[RD_LAT]) begin
        r_rdata <= bram_dout;
      end
    end
  end

  assign gnt       = r_gnt;
  assign bram_wren = r_wren;
  assign bram_rden = r_rden;
  assign bram_addr = r_addr;
  assign bram_din  = r_din;
  assign rvalid    = r_rvalid;
  assign rdata     = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_bram_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_bram_port_arbiter                                    |
// | Purpose  : Self-checking bench for bram_port_arbiter with a BRAM   |
// |            behavioural model and a transaction-level reference.    |
// |            Lock scenario is compiled when BRAM_ARB_LOCK_EN is set. |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module tb_bram_port_arbiter;

  localparam int NREQ   = 4;
  localparam int AW     = 10;
  localparam int DW     = 16;
  localparam int RD_LAT = 1;
  localparam int BW     = 2*NREQ + 2 + AW + 2*DW;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ-1:0]    we = '0;
  logic [NREQ*AW-1:0] addr = '0;
  logic [NREQ*DW-1:0] wdata = '0;
`ifdef BRAM_ARB_LOCK_EN
  logic [NREQ-1:0]    lock = '0;
`endif
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rvalid;
  logic [DW-1:0]      rdata;
  logic               bram_wren;
  logic               bram_rden;
  logic [AW-1:0]      bram_addr;
  logic [DW-1:0]      bram_din;
  logic [DW-1:0]      bram_dout = '0;

  bram_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
`ifdef BRAM_ARB_LOCK_EN
    .lock      (lock),
`endif
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .bram_wren (bram_wren),
    .bram_rden (bram_rden),
    .bram_addr (bram_addr),
    .bram_din  (bram_din),
    .bram_dout (bram_dout)
  );

  always #5 clk = ~clk;

  // Preload pattern shared by the BRAM model and the reference shadow.
  function automatic logic [DW-1:0] init_val(input int a);
    if (a == 0) return 16'h00BB;
    if (a == 1) return 16'h00FF;
    return 16'hA000 | DW'(a);
  endfunction

  // BRAM port model, one-cycle read latency.
  logic [DW-1:0] mem [0:1023];
  initial for (int a = 0; a < 1024; a++) mem[a] = init_val(a);
  always @(posedge clk) begin
    if (bram_wren) mem[bram_addr] <= bram_din;
    if (bram_rden) bram_dout <= mem[bram_addr];
  end

  // Reference model state (transaction level).
  typedef struct { int due; int tag; logic [DW-1:0] data; } rd_t;
  rd_t             rq[$];
  logic [DW-1:0]   shadow [0:1023];
  int              m_ptr;
  int              m_owner;
  logic [NREQ-1:0] m_gnt;
  logic            m_wren, m_rden;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_din, m_rdata;
  logic [NREQ-1:0] m_rvalid;
  int              edge_cnt = 0;
  int              n_checks = 0;
  int              n_fail = 0;

  initial for (int a = 0; a < 1024; a++) shadow[a] = init_val(a);

  function automatic logic [BW-1:0] dut_vec();
    return {gnt, bram_wren, bram_rden, bram_addr, bram_din, rvalid, rdata};
  endfunction

  function automatic logic [BW-1:0] mdl_vec();
    return {m_gnt, m_wren, m_rden, m_addr, m_din, m_rvalid, m_rdata};
  endfunction

  task automatic model_reset();
    m_ptr = NREQ - 1; m_owner = -1; m_gnt = '0; m_wren = 1'b0; m_rden = 1'b0;
    m_addr = '0; m_din = '0; m_rdata = '0; m_rvalid = '0; rq.delete();
  endtask

  task automatic drive(input int i, input logic r, input logic w, input int a, input logic [DW-1:0] d);
    req[i] = r; we[i] = w; addr[i*AW +: AW] = AW'(a); wdata[i*DW +: DW] = d;
  endtask

  // Predict the outcome of one clock from the sampled requests, then advance.
  task automatic step();
    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] one;
    int              win, best, d;
    logic            w_we;
    logic [AW-1:0]   w_a;
    logic [DW-1:0]   w_d;
    rd_t             e;
`ifdef BRAM_ARB_LOCK_EN
    logic [NREQ-1:0] lk;
    lk = lock;
`endif
    one  = 1;
    elig = req & ~m_gnt;
`ifdef BRAM_ARB_LOCK_EN
    if (m_owner >= 0 && lk[m_owner]) elig = elig & (one << m_owner);
`endif
    win = -1; best = NREQ + 1; w_we = 1'b0; w_a = '0; w_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      d = (i - m_ptr - 1 + 2*NREQ) % NREQ;
      if (elig[i] && d < best) begin best = d; win = i; end
    end
    if (win >= 0) begin
      w_we = we[win]; w_a = addr[win*AW +: AW]; w_d = wdata[win*DW +: DW];
    end
    @(posedge clk);
    edge_cnt++;
    m_gnt = '0; m_wren = 1'b0; m_rden = 1'b0;
    if (win >= 0) begin
      m_gnt[win] = 1'b1; m_wren = w_we; m_rden = !w_we;
      m_addr = w_a; m_din = w_d; m_ptr = win;
      if (w_we) shadow[w_a] = w_d;
      else begin e.due = edge_cnt + RD_LAT + 1; e.tag = win; e.data = shadow[w_a]; rq.push_back(e); end
    end
`ifdef BRAM_ARB_LOCK_EN
    if (win >= 0 && lk[win]) m_owner = win;
    else if (m_owner >= 0 && !lk[m_owner]) m_owner = -1;
`endif
    m_rvalid = '0;
    if (rq.size() > 0 && rq[0].due == edge_cnt) begin
      m_rvalid[rq[0].tag] = 1'b1; m_rdata = rq[0].data; void'(rq.pop_front());
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;
`ifdef BRAM_ARB_LOCK_EN
    lock = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (dut_vec() !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 0", dut_vec());
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_interleaved();
    logic [NREQ-1:0] rv_q[$];
    logic [DW-1:0]   rd_q[$];
    int              ed_q[$];
    drive(1, 1'b1, 1'b0, 1, '0);
    drive(3, 1'b1, 1'b0, 0, '0);
    for (int k = 0; k < 6; k++) begin
      step();
      n_checks++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL interleaved_cycle edge %0d: got %h expected %h", edge_cnt, dut_vec(), mdl_vec());
      end
      for (int i = 0; i < NREQ; i++) if (m_gnt[i]) req[i] = 1'b0;
      if (rvalid != '0) begin rv_q.push_back(rvalid); rd_q.push_back(rdata); ed_q.push_back(edge_cnt); end
    end
    n_checks++;
    if (rv_q.size() != 2) begin
      n_fail++; $display("FAIL interleaved_count: got %0d returns expected 2", rv_q.size());
    end else begin
      n_checks++;
      if (rv_q[0] !== 4'b0010 || rd_q[0] !== 16'h00FF) begin
        n_fail++; $display("FAIL interleaved_first: got rvalid %b rdata %h expected 0010 00ff", rv_q[0], rd_q[0]);
      end
      n_checks++;
      if (rv_q[1] !== 4'b1000 || rd_q[1] !== 16'h00BB || ed_q[1] != ed_q[0] + 1) begin
        n_fail++; $display("FAIL interleaved_second: got rvalid %b rdata %h gap %0d expected 1000 00bb gap 1", rv_q[1], rd_q[1], ed_q[1] - ed_q[0]);
      end
    end
  endtask

  task automatic test_single_wr_rd();
    int n_g = 0, n_dut_g = 0, rd_edge = -100, rv_edge = -1;
    logic [NREQ-1:0] rv_v = '0;
    logic [DW-1:0]   rv_d = '0;
    drive(0, 1'b1, 1'b1, 5, 16'h0066);
    for (int k = 0; k < 7; k++) begin
      step();
      n_checks++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL single_wr_rd_cycle edge %0d: got %h expected %h", edge_cnt, dut_vec(), mdl_vec());
      end
      if (gnt[0]) n_dut_g++;
      if (rvalid != '0 && rv_edge < 0) begin rv_edge = edge_cnt; rv_v = rvalid; rv_d = rdata; end
      if (m_gnt[0]) begin
        n_g++;
        if (n_g == 1) drive(0, 1'b1, 1'b0, 5, '0);
        else begin req[0] = 1'b0; rd_edge = edge_cnt; end
      end
    end
    n_checks++;
    if (n_dut_g != 2) begin
      n_fail++; $display("FAIL single_wr_rd_gnt_count: got %0d expected 2", n_dut_g);
    end
    // Read sampled in the cycle before rd_edge; data returns RD_LAT+2 cycles after that.
    n_checks++;
    if (rv_edge != rd_edge + RD_LAT + 1 || rv_v !== 4'b0001 || rv_d !== 16'h0066) begin
      n_fail++; $display("FAIL single_wr_rd_return: got edge %0d rvalid %b rdata %h expected edge %0d 0001 0066", rv_edge, rv_v, rv_d, rd_edge + RD_LAT + 1);
    end
  endtask

  task automatic test_fairness();
    int s;
    logic [NREQ-1:0] one, exp_g;
    one = 1;
    s = (m_ptr + 1) % NREQ;
    for (int i = 0; i < NREQ; i++) drive(i, 1'b1, 1'b1, 32 + i, DW'($urandom));
    for (int k = 0; k < 16; k++) begin
      step();
      exp_g = one << ((s + k) % NREQ);
      n_checks++;
      if (gnt !== exp_g || dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL fairness_order edge %0d: got gnt %b vec %h expected gnt %b vec %h", edge_cnt, gnt, dut_vec(), exp_g, mdl_vec());
      end
      for (int i = 0; i < NREQ; i++) if (m_gnt[i]) drive(i, 1'b1, 1'b1, 32 + i, DW'($urandom));
    end
    req = '0;
    step();
  endtask

  task automatic test_lone();
    int          n_g = 0;
    int          g_edges[$];
    logic [DW-1:0] got[$];
    drive(2, 1'b1, 1'b0, 7, '0);
    for (int k = 0; k < 14; k++) begin
      step();
      n_checks++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL lone_cycle edge %0d: got %h expected %h", edge_cnt, dut_vec(), mdl_vec());
      end
      if (gnt[2]) g_edges.push_back(edge_cnt);
      if (rvalid[2]) got.push_back(rdata);
      if (m_gnt[2]) begin
        n_g++;
        if (n_g < 3) drive(2, 1'b1, 1'b0, 7 + n_g, '0);
        else req[2] = 1'b0;
      end
    end
    n_checks++;
    if (g_edges.size() != 3 || got.size() != 3) begin
      n_fail++; $display("FAIL lone_counts: got %0d grants %0d returns expected 3 3", g_edges.size(), got.size());
    end else begin
      n_checks++;
      if (g_edges[1] - g_edges[0] != 2 || g_edges[2] - g_edges[1] != 2) begin
        n_fail++; $display("FAIL lone_spacing: got gaps %0d %0d expected 2 2", g_edges[1] - g_edges[0], g_edges[2] - g_edges[1]);
      end
      for (int j = 0; j < 3; j++) begin
        n_checks++;
        if (got[j] !== init_val(7 + j)) begin
          n_fail++; $display("FAIL lone_data[%0d]: got %h expected %h", j, got[j], init_val(7 + j));
        end
      end
    end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      step();
      n_checks++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL random_cycle edge %0d: got %h expected %h", edge_cnt, dut_vec(), mdl_vec());
      end
      for (int i = 0; i < NREQ; i++) begin
        if (m_gnt[i]) begin
          if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
          else drive(i, 1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(16, 47)), DW'($urandom));
        end else if (!req[i] && $urandom_range(0, 9) < 4) begin
          drive(i, 1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(16, 47)), DW'($urandom));
        end
      end
    end
    req = '0;
    repeat (4) begin
      step();
      n_checks++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL random_drain edge %0d: got %h expected %h", edge_cnt, dut_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_reset_mid_read();
    drive(2, 1'b1, 1'b0, 8, '0);
    step();
    n_checks++;
    if (gnt !== 4'b0100 || !bram_rden) begin
      n_fail++; $display("FAIL midreset_issue: got gnt %b rden %b expected 0100 1", gnt, bram_rden);
    end
    req[2] = 1'b0;
    drive(1, 1'b1, 1'b0, 9, '0);
    drive(3, 1'b1, 1'b0, 7, '0);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (dut_vec() !== '0) begin
      n_fail++; $display("FAIL midreset_outputs: got %h expected 0", dut_vec());
    end
    repeat (3) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (dut_vec() !== '0) begin
        n_fail++; $display("FAIL midreset_hold: got %h expected 0", dut_vec());
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step();
    n_checks++;
    if (gnt !== 4'b0010 || dut_vec() !== mdl_vec()) begin
      n_fail++; $display("FAIL midreset_first_grant: got gnt %b vec %h expected gnt 0010 vec %h", gnt, dut_vec(), mdl_vec());
    end
    req[1] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      n_checks++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL midreset_after edge %0d: got %h expected %h", edge_cnt, dut_vec(), mdl_vec());
      end
      if (m_gnt[3]) req[3] = 1'b0;
    end
  endtask

`ifdef BRAM_ARB_LOCK_EN
  task automatic test_lock();
    int n0 = 0, g1_edge = -1, last0_edge = -1, n0_at_g1 = -1;
    test_reset();
    drive(0, 1'b1, 1'b1, 40, 16'h1111);
    lock[0] = 1'b1;
    drive(1, 1'b1, 1'b1, 44, 16'h2222);
    for (int k = 0; k < 16; k++) begin
      step();
      n_checks++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL lock_cycle edge %0d: got %h expected %h", edge_cnt, dut_vec(), mdl_vec());
      end
      if (gnt[1] && g1_edge < 0) begin g1_edge = edge_cnt; n0_at_g1 = n0; end
      if (gnt[0]) last0_edge = edge_cnt;
      if (m_gnt[0]) begin
        n0++;
        if (n0 < 3) drive(0, 1'b1, 1'b1, 40 + n0, DW'(16'h1111 + n0));
        else begin req[0] = 1'b0; lock[0] = 1'b0; end
      end
      if (m_gnt[1]) req[1] = 1'b0;
    end
    n_checks++;
    if (g1_edge < 0 || n0_at_g1 != 3 || g1_edge != last0_edge + 1) begin
      n_fail++; $display("FAIL lock_handover: got gnt1 edge %0d after %0d owner grants expected edge %0d after 3", g1_edge, n0_at_g1, last0_edge + 1);
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    test_reset();
    test_interleaved();
    test_single_wr_rd();
    test_fairness();
    test_lone();
    test_random();
    test_reset_mid_read();
`ifdef BRAM_ARB_LOCK_EN
    test_lock();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares one port of the true dual-port 16-bit x 1024 BRAM (truedual) among NREQ requesters, using round-robin arbitration.
- Each requester issues single-word reads or writes through a req/gnt handshake.
- Drives the BRAM port's wren/rden/addr/din signals from registers.
- Returns read data tagged to the requester that issued the read.
- One instance sits in front of each BRAM port (A and B).

Parameters:
NREQ, 4, number of requesters (2..8)
AW, 10, BRAM address width
DW, 16, BRAM data width
RD_LAT, 1, BRAM read latency in clocks (rden to dout valid)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  NREQ  request per requester; held until gnt
we  in  NREQ  1=write, 0=read; qualified by req
addr  in  NREQ*AW  packed addresses; requester i at [i*AW +: AW]
wdata  in  NREQ*DW  packed write data; requester i at [i*DW +: DW]
gnt  out  NREQ  one-hot, one-cycle pulse: request issued to BRAM this cycle
rvalid  out  NREQ  one-hot, one-cycle pulse: rdata belongs to requester i
rdata  out  DW  registered read data
bram_wren  out  1  to BRAM wren
bram_rden  out  1  to BRAM rden
bram_addr  out  AW  to BRAM addr
bram_din  out  DW  to BRAM din
bram_dout  in  DW  from BRAM dout

Behaviour:
- Reset values:
  - All outputs are 0 on reset.
  - rr_ptr = NREQ-1, so requester 0 wins first.
  - Mask cleared; read-tag pipeline flushed.
- Reset mid-operation: in-flight reads never produce rvalid; a pending req is re-arbitrated after reset release.
- No explicit FSM. State consists of rr_ptr, last_gnt mask, a read-tag shift register of depth RD_LAT+1, and the lock owner (with the optional feature).
- Arbitration, evaluated every cycle t on the sampled req:
  - eligible = req & ~last_gnt, where last_gnt is the gnt vector of cycle t (prevents double issue while the requester sees gnt).
  - Winner = first eligible index searching rr_ptr+1, rr_ptr+2, ... mod NREQ.
- Issue, registered at edge t+1:
  - gnt[winner]=1.
  - bram_addr/bram_din = winner's addr/wdata.
  - bram_wren = we[winner]; bram_rden = ~we[winner].
  - rr_ptr = winner.
- No eligible requester: gnt=0, wren=rden=0, bram_addr/bram_din hold their last values, rr_ptr unchanged.
- Throughput: at most 1 access/cycle aggregate and 1 access per 2 cycles per requester.
- Requester rule: after seeing gnt, it may keep req high with new addr/we/wdata as a new request, or drop req. addr/we/wdata must be stable while req is high and gnt is not yet seen.
- Read return:
  - Read issued (bram_rden=1) at cycle c.
  - bram_dout is sampled at c+RD_LAT.
  - rdata and rvalid[owner] are registered at c+RD_LAT+1.
  - Request-to-rvalid latency = RD_LAT+2 cycles after req is sampled.
  - Writes produce no rvalid.
- rdata holds its value when rvalid=0.
- Back-to-back reads from different requesters return in issue order, one per cycle.
- Same-address write then read by different requesters: the read sees the new data, because the accesses are issued sequentially on one port. Cross-port collisions are outside this block.
- NREQ not a power of two: pointer wrap is handled mod NREQ, never by bit truncation.

Optional Feature:
- Macro: BRAM_ARB_LOCK_EN.
- Defined:
  - Adds input lock (NREQ).
  - When requester i is granted with lock[i]=1, it becomes owner; eligible is restricted to the owner (still subject to last_gnt masking).
  - Ownership ends on the first cycle the owner's lock is 0, or on reset.
  - Owner dropping req while lock=1 idles the port.
- Undefined: no lock port; pure round-robin as above.

Test Plan:
- Single write then read: req0 write addr=5, wdata=0x0066; then req0 read addr=5 -> gnt[0] pulses twice; rvalid[0] with rdata=0x0066 exactly 3 cycles (RD_LAT=1) after the read req is sampled.
- Fairness: req[3:0]=4'hF continuously, all writes -> gnt sequence 0,1,2,3,0,... one per cycle; no requester granted in two consecutive cycles.
- Lone requester: only req2 held high, reads to addr 7,8,9 -> gnt[2] every other cycle; rvalid[2] pulses in address order with the preloaded data.
- Interleaved reads: req1 read addr=1 (data 0x00FF), req3 read addr=0 (data 0x00BB) -> rvalid[1] with 0x00FF, then next cycle rvalid[3] with 0x00BB.
- Reset mid-read: assert rst_n=0 one cycle after gnt for a read -> no rvalid; all outputs 0; after release, first grant goes to lowest index with req.
- BRAM_ARB_LOCK_EN: req0 lock=1 issuing 3 writes while req1 pending -> gnt[1] only after lock[0] falls.
